// File: rtl/param_fifo_pkg.sv
// Shared types, default parameters and the threshold legality check for param_fifo.
// Optional feature macro: PARAM_FIFO_FWFT_EN (first-word-fall-through read mode).
package param_fifo_pkg;

  localparam int DEF_DATA_WIDTH             = 8;
  localparam int DEF_INDEX_WIDTH            = 5;
  localparam int DEF_ALMOST_FULL_THRESHOLD  = 28;
  localparam int DEF_ALMOST_EMPTY_THRESHOLD = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } status_t;

  function automatic bit thresholds_ok(input int depth, input int af_thr, input int ae_thr);
    return (af_thr <= depth) && (ae_thr < af_thr);
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake/status bundle between param_fifo (slave) and its producer/consumer (master).
// Optional feature macro: PARAM_FIFO_FWFT_EN (changes only the meaning of rd_data/rd_valid).
interface param_fifo_if
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
);

  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_valid;
  logic                   flush;
  logic                   clr_err;
  logic [INDEX_WIDTH:0]   count;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output wr_en, wr_data, rd_en, flush, clr_err,
    input  rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, flush, clr_err,
    output rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

endinterface

// File: rtl/param_fifo_mem.sv
// DEPTH x DATA_WIDTH storage, one write port, one combinational read port.
// Kept separate so it can be swapped for an SRAM macro; contents are never reset.
module param_fifo_mem
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [INDEX_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO: pointers, status/error flags and the read output stage.
// Optional feature macro: PARAM_FIFO_FWFT_EN selects first-word-fall-through reads.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH            = DEF_INDEX_WIDTH,
  parameter int ALMOST_FULL_THRESHOLD  = DEF_ALMOST_FULL_THRESHOLD,
  parameter int ALMOST_EMPTY_THRESHOLD = DEF_ALMOST_EMPTY_THRESHOLD
) (
  input  logic         clk,
  input  logic         rst_n,
  param_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam int PW    = INDEX_WIDTH + 1;

  if (!thresholds_ok(DEPTH, ALMOST_FULL_THRESHOLD, ALMOST_EMPTY_THRESHOLD) || DATA_WIDTH < 1)
  begin : g_bad_params
    $error("param_fifo: illegal DATA_WIDTH or almost-full/almost-empty thresholds");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  status_t               status;

  // Extra pointer bit disambiguates full from empty; subtraction wraps naturally.
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    status.full         = (count == PW'(DEPTH));
    status.empty        = (count == '0);
    status.almost_full  = (int'(count) >= ALMOST_FULL_THRESHOLD);
    status.almost_empty = (int'(count) <= ALMOST_EMPTY_THRESHOLD);
  end

  always_comb begin
    wr_acc      = bus.wr_en && !status.full  && !bus.flush;
    rd_acc      = bus.rd_en && !status.empty && !bus.flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    // Flush swallows the cycle's requests, so they can neither move nor flag.
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (bus.wr_en && status.full)  overflow_d  = 1'b1;
      if (bus.rd_en && status.empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  param_fifo_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[INDEX_WIDTH-1:0]),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr_q[INDEX_WIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

`ifdef PARAM_FIFO_FWFT_EN
  // Head entry is always presented; rd_en only acknowledges it.
  assign bus.rd_data  = mem_rd_data;
  assign bus.rd_valid = !status.empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_acc ? mem_rd_data : rd_data_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.count        = count;
  assign bus.full         = status.full;
  assign bus.empty        = status.empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo with default parameters; follows PARAM_FIFO_FWFT_EN if defined.
module tb_param_fifo;
  import param_fifo_pkg::*;

  localparam int DW = 8;
  localparam int IW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_fifo_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

  param_fifo #(
    .DATA_WIDTH             (DW),
    .INDEX_WIDTH            (IW),
    .ALMOST_FULL_THRESHOLD  (28),
    .ALMOST_EMPTY_THRESHOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] model_q [$];
  logic [7:0] exp_d;
  logic [7:0] d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    if (obs === exp) $display("ok %s = %0h", tag, obs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_count"},  32'(bus.count), 0);
    check({pfx, "_empty"},  32'(bus.empty), 1);
    check({pfx, "_aempty"}, 32'(bus.almost_empty), 1);
    check({pfx, "_full"},   32'(bus.full), 0);
    check({pfx, "_afull"},  32'(bus.almost_full), 0);
    check({pfx, "_ovf"},    32'(bus.overflow), 0);
    check({pfx, "_udf"},    32'(bus.underflow), 0);
    check({pfx, "_valid"},  32'(bus.rd_valid), 0);
`ifndef PARAM_FIFO_FWFT_EN
    check({pfx, "_rdata"},  32'(bus.rd_data), 0);
`endif
  endtask

  task automatic push(input logic [7:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] v);
`ifdef PARAM_FIFO_FWFT_EN
    check({tag, "_valid"}, 32'(bus.rd_valid), 1);
    check({tag, "_data"},  32'(bus.rd_data), 32'(v));
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
`else
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check({tag, "_valid"}, 32'(bus.rd_valid), 1);
    check({tag, "_data"},  32'(bus.rd_data), 32'(v));
`endif
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
    bus.flush = 1'b0; bus.clr_err = 1'b0;

    // reset state
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // push 0x01..0x05 then pop in order
    for (int i = 1; i <= 5; i++) begin
      push(8'(i));
      check("t1_count", 32'(bus.count), 32'(i));
    end
    for (int i = 1; i <= 5; i++) pop_expect("t1_pop", 8'(i));
    step();
    check("t1_count_end", 32'(bus.count), 0);
    check("t1_empty_end", 32'(bus.empty), 1);
`ifndef PARAM_FIFO_FWFT_EN
    check("t1_valid_drop", 32'(bus.rd_valid), 0);
    check("t1_data_hold",  32'(bus.rd_data), 32'h05);
`endif

    // fill to 32, overflow, drain
    for (int k = 0; k < 32; k++) begin
      push(8'(8'h10 + k));
      check("t2_count", 32'(bus.count), 32'(k + 1));
      check("t2_afull", 32'(bus.almost_full), 32'((k + 1) >= 28));
      check("t2_full",  32'(bus.full), 32'((k + 1) == 32));
    end
    push(8'hEE);
    check("t2_ovf",       32'(bus.overflow), 1);
    check("t2_ovf_count", 32'(bus.count), 32);
    for (int k = 0; k < 32; k++) begin
      pop_expect("t2_pop", 8'(8'h10 + k));
      check("t2_aempty", 32'(bus.almost_empty), 32'((31 - k) <= 4));
    end
    check("t2_empty", 32'(bus.empty), 1);

    // error flags: clear, underflow, set-wins
    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
    check("t3_ovf_clr", 32'(bus.overflow), 0);
    bus.rd_en = 1'b1;
    step();
    check("t3_udf",       32'(bus.underflow), 1);
    check("t3_udf_valid", 32'(bus.rd_valid), 0);
    step();
    check("t3_udf_hold",  32'(bus.underflow), 1);
    bus.rd_en = 1'b0; bus.clr_err = 1'b1;
    step();
    check("t3_udf_clr",   32'(bus.underflow), 0);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    check("t3_set_wins",  32'(bus.underflow), 1);
    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
    check("t3_udf_clr2",  32'(bus.underflow), 0);

    // fill to 10, then 100 cycles of simultaneous push/pop
    for (int i = 0; i < 10; i++) begin
      d = 8'(8'h40 + i);
      push(d);
      model_q.push_back(d);
    end
    check("t4_count_fill", 32'(bus.count), 10);
    for (int c = 0; c < 100; c++) begin
      d = 8'(8'h80 + c);
      bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = d;
      model_q.push_back(d);
      exp_d = model_q.pop_front();
`ifdef PARAM_FIFO_FWFT_EN
      check("t4_data", 32'(bus.rd_data), 32'(exp_d));
      step();
`else
      step();
      check("t4_valid", 32'(bus.rd_valid), 1);
      check("t4_data",  32'(bus.rd_data), 32'(exp_d));
`endif
      check("t4_count", 32'(bus.count), 10);
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;

    // fill to 20, then flush with requests pending
    for (int i = 0; i < 10; i++) push(8'(8'hC0 + i));
    check("t5_count20", 32'(bus.count), 20);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 8'h99;
    step();
    bus.flush = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("t5_count", 32'(bus.count), 0);
    check("t5_empty", 32'(bus.empty), 1);
    check("t5_ovf",   32'(bus.overflow), 0);
    check("t5_udf",   32'(bus.underflow), 0);
    check("t5_valid", 32'(bus.rd_valid), 0);
    model_q.delete();

    // asynchronous reset mid-burst
    push(8'h31); push(8'h32); push(8'h33);
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 8'h34;
    step();
`ifndef PARAM_FIFO_FWFT_EN
    check("t6_burst_data", 32'(bus.rd_data), 32'h31);
`endif
    check("t6_burst_count", 32'(bus.count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("t6_rst");
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h77);
    check("t6_post_count", 32'(bus.count), 1);
    pop_expect("t6_post_pop", 8'h77);
    check("t6_post_empty", 32'(bus.empty), 1);

`ifdef PARAM_FIFO_FWFT_EN
    // fall-through: data visible one cycle after the write, no rd_en needed
    push(8'hA5);
    check("t7_valid", 32'(bus.rd_valid), 1);
    check("t7_data",  32'(bus.rd_data), 32'hA5);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("t7_empty", 32'(bus.empty), 1);
    check("t7_valid_off", 32'(bus.rd_valid), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
